// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer. It runs a radix-2 shift-add multiply or a restoring divide.
// Latency: done pulses WIDTH+2 cycles after the start edge. Divide-by-zero and signed overflow take 1 cycle.
// Backpressure: busy requests a pipeline stall. start is only sampled in IDLE/DONE. flush aborts at once.
// Ports: clk/rst_n (async active-low); start/op/operand_a/operand_b issue one operation;
//        flush aborts; busy = CALC|FIX; done = one-cycle result pulse; result holds the last value.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    ITERS   = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state_q, state_d;

  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand |a| for multiply, divisor |b| for divide
  logic [WIDTH-1:0] hi_q;     // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;     // multiplier then product low half / dividend then quotient
  logic             neg_q_q;  // product or quotient must be negated
  logic             neg_r_q;  // remainder must be negated (follows the dividend)
  logic [WIDTH-1:0] result_q;

  // Operand decode at the issue edge
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             div_zero, div_ovf, short_path, accept;
  logic [WIDTH-1:0] short_res;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                 a_signed = 1'b1;
      default:                ;
    endcase
  end

  assign a_neg      = a_signed & operand_a[WIDTH-1];
  assign b_neg      = b_signed & operand_b[WIDTH-1];
  assign abs_a      = a_neg ? (~operand_a + 1'b1) : operand_a;
  assign abs_b      = b_neg ? (~operand_b + 1'b1) : operand_b;
  assign div_zero   = (operand_b == '0);
  // Only DIV/REM (op[0]=0) are signed, so only they can overflow
  assign div_ovf    = ~op[0] & (operand_a == MIN_NEG) & (operand_b == '1);
  assign short_path = op[2] & (div_zero | div_ovf);
  assign short_res  = div_zero ? (op[1] ? operand_a : '1) : (op[1] ? '0 : MIN_NEG);
  assign accept     = start & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));

  // One iteration of each algorithm
  logic [WIDTH:0] mul_sum, rem_sh, rem_sub;
  logic           rem_ge;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign rem_sh  = {hi_q, lo_q[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, opnd_q});
  assign rem_sub = rem_sh - {1'b0, opnd_q};

  // Sign correction and result selection
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fix_res;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q_q ? (~prod + 1'b1) : prod;

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = neg_q_q ? (~lo_q + 1'b1) : lo_q;
      default:                fix_res = neg_r_q ? (~hi_q + 1'b1) : hi_q;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start)                  state_d = short_path ? S_DONE : S_CALC;
          else                        state_d = S_IDLE;
        end
        S_CALC: if (cnt_q == CW'(1)) state_d = S_FIX;
        S_FIX:                        state_d = S_DONE;
        default:                      state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= op;
      cnt_q   <= ITERS;
      opnd_q  <= op[2] ? abs_b : abs_a;
      lo_q    <= op[2] ? abs_a : abs_b;
      hi_q    <= '0;
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
      if (short_path) result_q <= short_res;
    end else if (!flush && state_q == S_CALC) begin
      cnt_q <= cnt_q - 1'b1;
      if (op_q[2]) begin
        // Restoring divide: shift in the next dividend bit, keep the subtraction if it did not go negative
        hi_q <= rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], rem_ge};
      end else begin
        // Shift-add: the carry of the add becomes the new top bit after the right shift
        hi_q <= mul_sum[WIDTH:1];
        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end else if (!flush && state_q == S_FIX) begin
      result_q <= fix_res;
    end
  end

  assign busy   = (state_q == S_CALC) | (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq against an arithmetic reference model.
// Latency: checks the done timing, counted in cycles from the issue edge.
// Backpressure: exercises start during busy, back-to-back issue, flush and asynchronous reset.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = '0;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i),
    .operand_a(a_i), .operand_b(b_i), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M semantics with wide integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      3'd0: begin up = ua * ub;           return up[31:0];  end
      3'd1: begin p  = sa * sb;           return p[63:32];  end
      3'd2: begin p  = sa * longint'(ub); return p[63:32];  end
      3'd3: begin up = ua * ub;           return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        return 32'(ia / ib);
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  // Issue one op and observe it. done_k is the cycle after the issue edge in which done was seen (0 = never).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int done_k, output int busy_n, output bit overlap);
    done_k = 0; busy_n = 0; overlap = 1'b0; res = '0;
    @(negedge clk);
    op_i = o; a_i = a; b_i = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;  // captured operands must not follow these
    for (int k = 1; k <= 80; k++) begin
      if (busy) busy_n++;
      if (busy && done) overlap = 1'b1;
      if (done) begin done_k = k; res = result; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== '0)  begin errors++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res; int dk, bn; bit ov;
    run_op(o, a, b, res, dk, bn, ov);
    checks++; if (res !== exp_res) begin errors++; $display("FAIL %s_result got %h want %h", name, res, exp_res); end
    checks++; if (dk != exp_lat)   begin errors++; $display("FAIL %s_latency got %0d want %0d", name, dk, exp_lat); end
    checks++; if (bn != exp_lat - 1) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bn, exp_lat - 1); end
    checks++; if (ov !== 1'b0)     begin errors++; $display("FAIL %s_busy_done_overlap got %b want 0", name, ov); end
    last_res = exp_res;
  endtask

  task automatic test_mul();
    test_directed("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    test_directed("mulh",   3'd1, MIN_NEG,      MIN_NEG,       32'h4000_0000, 34);
    test_directed("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    test_directed("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
  endtask

  task automatic test_div();
    test_directed("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    test_directed("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    test_directed("divu", 3'd5, 32'd100,       32'd7, 32'd14,        34);
    test_directed("remu", 3'd7, 32'd100,       32'd7, 32'd2,         34);
  endtask

  task automatic test_short_path();
    test_directed("div_by_zero",  3'd4, 32'd5,   32'd0,         32'hFFFF_FFFF, 1);
    test_directed("remu_by_zero", 3'd7, 32'd5,   32'd0,         32'd5,         1);
    test_directed("div_overflow", 3'd4, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG,       1);
    test_directed("rem_overflow", 3'd6, MIN_NEG, 32'hFFFF_FFFF, 32'd0,         1);
  endtask

  task automatic test_random();
    logic [2:0] o; logic [31:0] a, b, res, exp_res; int dk, bn, exp_lat, sel; bit ov;
    for (int n = 0; n < 40; n++) begin
      o = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = $urandom_range(1, 15);
      if (sel == 3) a = $urandom_range(0, 100);
      exp_res = ref_model(o, a, b);
      exp_lat = ref_latency(o, a, b);
      run_op(o, a, b, res, dk, bn, ov);
      checks++; if (res !== exp_res) begin errors++; $display("FAIL rand_result op=%0d a=%h b=%h got %h want %h", o, a, b, res, exp_res); end
      checks++; if (dk != exp_lat)   begin errors++; $display("FAIL rand_latency op=%0d got %0d want %0d", o, dk, exp_lat); end
      checks++; if (ov !== 1'b0)     begin errors++; $display("FAIL rand_overlap op=%0d got %b want 0", o, ov); end
      last_res = exp_res;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, r1, r2, e1, e2;
    int d1 = 0, d2 = 0;
    logic first_busy = 1'b0, first_done = 1'b1;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
    e1 = ref_model(3'd1, a1, b1);
    e2 = ref_model(3'd6, a2, b2);
    r1 = '0; r2 = '0;
    @(negedge clk);
    op_i = 3'd1; a_i = a1; b_i = b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (done) begin d1 = k; r1 = result; break; end
      // Stray request during CALC: must be dropped
      if (k == 5) begin start = 1'b1; op_i = 3'd5; a_i = $urandom; b_i = $urandom; end
      if (k == 6) start = 1'b0;
      @(negedge clk);
    end
    // Hold start through the DONE cycle with the next op
    op_i = 3'd6; a_i = a2; b_i = b2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    first_busy = busy; first_done = done;
    for (int k = 1; k <= 80; k++) begin
      if (done) begin d2 = k; r2 = result; break; end
      @(negedge clk);
    end
    checks++; if (r1 !== e1)         begin errors++; $display("FAIL b2b_first_result got %h want %h", r1, e1); end
    checks++; if (d1 != 34)          begin errors++; $display("FAIL b2b_first_latency got %0d want 34", d1); end
    checks++; if (first_busy !== 1'b1 || first_done !== 1'b0)
                                      begin errors++; $display("FAIL b2b_no_bubble got busy=%b done=%b want busy=1 done=0", first_busy, first_done); end
    checks++; if (d2 != 34)          begin errors++; $display("FAIL b2b_done_spacing got %0d want 34", d2); end
    checks++; if (r2 !== e2)         begin errors++; $display("FAIL b2b_second_result got %h want %h", r2, e2); end
    last_res = e2;
    @(negedge clk);
  endtask

  task automatic test_flush();
    int saw_done = 0;
    @(negedge clk);
    op_i = 3'd0; a_i = $urandom; b_i = $urandom; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    checks++; if (result !== last_res) begin errors++; $display("FAIL flush_result_kept got %h want %h", result, last_res); end
    for (int k = 0; k < 40; k++) begin
      if (done) saw_done++;
      @(negedge clk);
    end
    checks++; if (saw_done != 0)       begin errors++; $display("FAIL flush_no_done got %0d pulses want 0", saw_done); end
    // flush wins over start on the same edge
    op_i = 3'd5; a_i = 32'd9; b_i = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0)
                                        begin errors++; $display("FAIL flush_priority got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (result !== last_res) begin errors++; $display("FAIL flush_priority_result got %h want %h", result, last_res); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res; int dk, bn; bit ov;
    @(negedge clk);
    op_i = 3'd3; a_i = $urandom; b_i = $urandom; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 15; k++) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL areset_done got %b want 0", done); end
    checks++; if (result !== '0)   begin errors++; $display("FAIL areset_result got %h want 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd5, 32'd100, 32'd7, res, dk, bn, ov);
    checks++; if (res !== 32'd14 || dk != 34)
                                    begin errors++; $display("FAIL areset_recover got %h lat %0d want 0000000e lat 34", res, dk); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_short_path();
    test_back_to_back();
    test_random();
    test_directed("prep", 3'd5, 32'd100, 32'd7, 32'd14, 34);
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multi-cycle sequencer for the RV32M multiply/divide instructions, sitting in the EX stage beside the single-cycle ALU. It accepts one operation per start pulse and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles. It asserts busy so the hazard unit can stall IF/ID/EX, and presents a one-cycle done pulse with the result. It handles RISC-V divide-by-zero and signed-overflow cases on a short path.

Parameters:
WIDTH, 32, operand/result width; iteration count = WIDTH; counter width = $clog2(WIDTH)+1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  WIDTH  rs1 value (multiplicand/dividend)
operand_b  input  WIDTH  rs2 value (multiplier/divisor)
flush  input  1  pipeline flush; aborts the current operation
busy  output  1  high in CALC and FIX states (stall request)
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  result, held until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0; all internal registers cleared. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- Edge 1 is the rising edge on which start is accepted (start=1 in IDLE or DONE, flush=0). operand_a, operand_b and op are captured on edge 1 and ignored afterwards.
- Operand magnitudes:
  - MULH, DIV, REM: both operands treated as signed.
  - MULHSU: a signed, b unsigned.
  - Others: unsigned.
  - Negative signed operands are converted to absolute value on capture; the result sign is recorded.
- Short path (DIV/DIVU/REM/REMU only), decided from the operands at edge 1:
  - Divisor=0: quotient = all ones, remainder = operand_a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - State goes straight to DONE, so done is high in the cycle after edge 1.
- Normal path:
  - IDLE -> CALC on edge 1; counter loaded with WIDTH.
  - CALC: one iteration per edge, counter decrements; CALC -> FIX when the counter reaches 0 (edge WIDTH+1).
  - Multiply: 2*WIDTH-bit accumulator, add-if-LSB then shift right.
  - Divide: shift remainder left, trial-subtract, set quotient bit if the result is non-negative.
- FIX (one cycle):
  - Apply sign correction; the remainder takes the sign of the dividend.
  - Select the low product (MUL), high product (MULH/MULHSU/MULHU), quotient or remainder.
  - Register the selection into result; FIX -> DONE.
- Latency: done is high in the cycle after edge WIDTH+2 (34 for WIDTH=32).
- DONE lasts exactly one cycle with done=1 and busy=0.
  - DONE -> IDLE if start=0.
  - DONE -> CALC (or DONE, for the short path) if start=1, giving back-to-back issue with no bubble.
- start during CALC/FIX is ignored with no queueing; the requester must hold or re-issue it.
- flush=1 on any edge: next state IDLE; done not asserted; result keeps its previous value. flush has priority over start on the same edge.
- All arithmetic is modulo 2^WIDTH for 32-bit results; the product is exact in 2*WIDTH bits.
- done and busy are never high in the same cycle.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> done after edge 34, result=0xFFFFFFEB; busy high for 33 cycles.
- MULH a=b=0x80000000 -> result 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU on the same operands -> 2.
- Divide by zero:
  - DIV a=5, b=0 -> done after edge 1, result 0xFFFFFFFF, busy never high.
  - REMU a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
- Back-to-back: start held high across the DONE cycle with new operands -> second op accepted with no IDLE cycle; two done pulses exactly 34 cycles apart; start pulses during CALC ignored.
- Flush and reset:
  - flush at cycle 10 of CALC -> IDLE next cycle, no done, result unchanged.
  - rst_n low mid-CALC -> busy, done and result are 0 immediately, without waiting for a clock edge.
